round_timer: RTL
================

# round_timer

Per-round countdown timer for the binary number game. Sits directly downstream of the game-logic controller: consumes its round-start flag (`time_f`) and computed round length (`time_v`) and produces the time-expired flag (`end_f`) that the controller samples. Also exposes the remaining seconds for the display path.

## Interface
Parameters:
- `TICK_DIV`, default 50_000_000: clock cycles per one-second tick (≥2).
- `MIN_SECONDS`, default 3: floor applied to the loaded round length.

Ports:
- `clk`  in  1: system clock; all state is on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `time_f`  in  1: round-start flag, a level. Its rising edge (re)starts the timer.
- `time_v`  in  5: round length in seconds, sampled on the cycle the `time_f` rising edge is detected.
- `stop`  in  1: abort/disarm, a level. Asserted while the controller is not in the guessing state.
- `end_f`  out  1: time expired, a level. Stays high until the next start or `stop`.
- `remaining`  out  5: seconds left.
- `running`  out  1: high while counting.
- `tick`  out  1: one-cycle pulse on every second boundary while running.

## Operation
- FSM has three states: IDLE, RUN, EXPIRED.
- **Edge detection:** a register `time_f_q` holds the previous `time_f`. `start_edge = time_f & ~time_f_q`.
- **Load:** on `start_edge`, `remaining ← max(time_v, MIN_SECONDS)`. Comparison is 5-bit unsigned. The prescaler clears, `end_f ← 0`, and the state goes to RUN.
- **RUN:**
  - The prescaler counts 0..TICK_DIV-1. At the wrap, `tick` pulses and `remaining` decrements.
  - When `remaining` is 1 at a tick, the following happen on that same edge: `remaining ← 0`, `end_f ← 1`, state goes to EXPIRED, `running ← 0`.
- **EXPIRED:** holds `end_f=1` and `remaining=0`. Leaves on `start_edge` (to RUN) or on `stop` (to IDLE).
- **stop:**
  - From any state, goes to IDLE and sets `end_f ← 0` and `running ← 0`.
  - `remaining` freezes at its current value so the display keeps it.
  - The prescaler clears.
- **Priority when events coincide:** reset > `stop` > `start_edge` > tick.
  - `stop` and `start_edge` in the same cycle: the result is IDLE.
  - `start_edge` on a tick cycle: the load wins and no decrement occurs.
- **Restart:** a `start_edge` while in RUN restarts with the new value.
- `remaining` never underflows. Decrement happens only in RUN with `remaining > 0`.

## Timing
- **Reset values:** state IDLE, `end_f=0`, `running=0`, `tick=0`, `remaining=0`, `time_f_q=0`, prescaler 0.
- **Start latency:** `time_f` first sampled high at edge N means `running=1` and `remaining` is loaded after edge N.
- **Tick cadence:** the first `tick` occurs TICK_DIV cycles after the load edge; later ticks follow every TICK_DIV cycles.
- **Expiry:** `end_f` rises exactly `L×TICK_DIV` cycles after the load edge, where L is the clamped load value.
- **Stop latency:** one cycle, i.e. outputs update on the edge that samples `stop=1`.
- **Output types:**
  - `tick` is registered and one cycle wide.
  - `end_f` is registered and glitch-free, so it is safe for an edge-triggered consumer.

## Configuration
- `ROUND_TIMER_BCD_EN` defined:
  - Adds outputs `rem_tens [3:0]` and `rem_ones [3:0]`, the BCD of `remaining` (0–31).
  - They are registered and updated on the same edge as `remaining`, so there is zero extra latency.
  - Their reset value is 0/0.
- Not defined: these ports and the logic behind them are absent, and the block has the binary `remaining` only.

## Structure
- **Shared package `game_pkg`:**
  - `SEC_W = 5` (width of seconds values).
  - `MIN_SECONDS_DEFAULT = 3`.
  - Enum `timer_state_t` {IDLE, RUN, EXPIRED}.
  - Consumers of `remaining` use `SEC_W`.
- **Sub-module `tick_prescaler`:**
  - Ports: `clk`, `rst_n`, `clr`, `en`; output `tick`.
  - Parameter `TICK_DIV`.
  - Counter width is `$clog2(TICK_DIV)`.
- **BCD conversion** is inline combinational logic (divide by 10 over 5 bits) feeding registers. It is compiled only under the macro.

## Test plan
All scenarios use `TICK_DIV=4` and `MIN_SECONDS=3`.
- **Basic countdown:** reset, then `time_f` 0→1 with `time_v=5`.
  - `running` goes 1 and `remaining` reads 5,4,3,2,1,0 at 4-cycle spacing.
  - `end_f` rises 20 cycles after load and stays high.
- **Clamp:** `time_v=1` at start → `remaining=3`, and `end_f` rises after 12 cycles.
- **Stop mid-round:** start with 10, assert `stop` after 9 cycles.
  - Next edge: `running=0`, `remaining=8` frozen, `end_f` stays 0.
  - No further ticks.
- **Restart:**
  - During RUN at `remaining=6`, lower and re-raise `time_f` with `time_v=4` → reload to 4, prescaler restarts, no decrement in the edge cycle.
  - From EXPIRED, a new start edge clears `end_f` on the load edge.
- **Coincidences and reset:**
  - `stop` and `start_edge` in the same cycle → IDLE, `end_f=0`.
  - `rst_n` low mid-RUN → all outputs are 0 immediately, without waiting for a clock edge.
- **BCD (macro defined):** load 31 → `rem_tens=3`, `rem_ones=1`; after two ticks → 2/9.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game definitions: seconds width, default round floor and timer states.
package game_pkg;

  localparam int unsigned SEC_W               = 5;
  localparam int unsigned MIN_SECONDS_DEFAULT = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } timer_state_t;

  function automatic logic [SEC_W-1:0] clamp_sec(input logic [SEC_W-1:0] v,
                                                 input logic [SEC_W-1:0] floor_v);
    return (v < floor_v) ? floor_v : v;
  endfunction

endpackage

// File: rtl/round_timer_tick_prescaler.sv
// Divides clk down to a one-second boundary; tick is the combinational wrap strobe
// so the parent can act on the same edge the counter wraps.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt_q;

  assign tick = en && !clr && (cnt_q == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/round_timer.sv
// Per-round countdown timer feeding end_f back to the game controller.
// Optional BCD display outputs are built when ROUND_TIMER_BCD_EN is defined.
module round_timer
  import game_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 50_000_000,
  parameter int unsigned MIN_SECONDS = MIN_SECONDS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             time_f,
  input  logic [SEC_W-1:0] time_v,
  input  logic             stop,
  output logic             end_f,
  output logic [SEC_W-1:0] remaining,
  output logic             running,
  output logic             tick
`ifdef ROUND_TIMER_BCD_EN
  ,
  output logic [3:0]       rem_tens,
  output logic [3:0]       rem_ones
`endif
);

  timer_state_t     state_q, state_d;
  logic             time_f_q;
  logic             start_edge;
  logic             sec_wrap;
  logic             end_f_d, running_d, tick_d;
  logic [SEC_W-1:0] remaining_d;

  assign start_edge = time_f & ~time_f_q;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (stop | start_edge),
    .en    (state_q == RUN),
    .tick  (sec_wrap)
  );

  // Next-state and output values; priority is stop > start_edge > tick.
  always_comb begin
    state_d     = state_q;
    end_f_d     = end_f;
    running_d   = running;
    remaining_d = remaining;
    tick_d      = 1'b0;
    if (stop) begin
      state_d   = IDLE;
      end_f_d   = 1'b0;
      running_d = 1'b0;
    end else if (start_edge) begin
      state_d     = RUN;
      end_f_d     = 1'b0;
      running_d   = 1'b1;
      remaining_d = clamp_sec(time_v, SEC_W'(MIN_SECONDS));
    end else if (state_q == RUN && sec_wrap) begin
      tick_d = 1'b1;
      if (remaining <= SEC_W'(1)) begin
        state_d     = EXPIRED;
        end_f_d     = 1'b1;
        running_d   = 1'b0;
        remaining_d = '0;
      end else begin
        remaining_d = remaining - SEC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      time_f_q  <= 1'b0;
      end_f     <= 1'b0;
      running   <= 1'b0;
      tick      <= 1'b0;
      remaining <= '0;
    end else begin
      state_q   <= state_d;
      time_f_q  <= time_f;
      end_f     <= end_f_d;
      running   <= running_d;
      tick      <= tick_d;
      remaining <= remaining_d;
    end
  end

`ifdef ROUND_TIMER_BCD_EN
  logic [3:0] tens_d, ones_d;

  // Divide-by-10 over 0..31 reduces to three threshold compares.
  always_comb begin
    tens_d = 4'd0;
    ones_d = 4'(remaining_d);
    if (remaining_d >= SEC_W'(30)) begin
      tens_d = 4'd3;
      ones_d = 4'(remaining_d - SEC_W'(30));
    end else if (remaining_d >= SEC_W'(20)) begin
      tens_d = 4'd2;
      ones_d = 4'(remaining_d - SEC_W'(20));
    end else if (remaining_d >= SEC_W'(10)) begin
      tens_d = 4'd1;
      ones_d = 4'(remaining_d - SEC_W'(10));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_tens <= 4'd0;
      rem_ones <= 4'd0;
    end else begin
      rem_tens <= tens_d;
      rem_ones <= ones_d;
    end
  end
`endif

endmodule
